hazard_ctrl_mc: RTL and testbench
=================================

Name: hazard_ctrl_mc

Overview:
Parametrised next-generation hazard controller for the 5-stage pipeline (F/D/E/M/W). It provides two-level operand forwarding (M and W producers to E consumers) and detects load-use hazards, inserting a bubble in E. It tracks multi-cycle E-stage operations (multiply/divide) with an occupancy FSM that holds F/D/E. Branches resolved in M flush D and E, and saturating stall and flush event counters are kept for performance analysis.

Parameters:
REG_W, 4, register-specifier width.
ZERO_REG_EN, 1, 1 = register 0 is never a forwarding source or hazard producer; 0 = register 0 is treated like any other register.
MC_LAT, 4, total cycles a multi-cycle op occupies E; legal range 2..2^8.
CNT_W, 16, performance counter width.

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
rsD  in  REG_W  source A of instruction in D
rtD  in  REG_W  source B of instruction in D
rsE  in  REG_W  source A of instruction in E
rtE  in  REG_W  source B of instruction in E
destRegE  in  REG_W  destination of instruction in E
loadE  in  1  instruction in E is a load
mcStartE  in  1  instruction in E is a multi-cycle op; held high while that op stays in E
writeM  in  1  M-stage instruction writes the register file
rdM  in  REG_W  M-stage destination
writeW  in  1  W-stage instruction writes the register file
rdW  in  REG_W  W-stage destination
branch_M  in  1  taken branch or redirect resolved in M
clrCounters  in  1  synchronous clear of the performance counters
stallF  out  1  hold PC
stallD  out  1  hold F/D register
stallE  out  1  hold D/E register (multi-cycle op only)
flushD  out  1  clear F/D register
flushE  out  1  clear D/E register (inserts a bubble)
forwardA  out  2  E operand A select
forwardB  out  2  E operand B select
mcBusy  out  1  FSM in BUSY
stallCount  out  CNT_W  cycles with stallD=1
flushCount  out  CNT_W  cycles with branch_M=1

Behaviour:
- Forwarding (combinational):
  - Encoding: 00 = register file, 01 = ALUResultM, 10 = ResultW.
  - forwardA=01 if writeM and rdM==rsE and the zero-register check passes; else 10 if writeW and rdW==rsE and the check passes; else 00. M has priority over W.
  - forwardB is the same rule applied to rtE.
  - The zero-register check applies only when ZERO_REG_EN=1: producer register must be !=0.
  - Forwarding is unaffected by reset, stalls and flushes.
- Load-use: lu = loadE and (destRegE==rsD or destRegE==rtD), with the zero-register exclusion applied to destRegE. When lu=1: stallF=stallD=1, flushE=1, stallE=0.
- Multi-cycle FSM: states IDLE and BUSY, with an 8-bit down-counter cnt.
  - IDLE with mcStartE=1: stallF=stallD=stallE=1; next state BUSY with cnt=MC_LAT-2.
  - BUSY with cnt!=0: stallF/D/E=1 and cnt decrements.
  - BUSY with cnt==0: no stall; next state IDLE. The op leaves E at this edge.
  - mcStartE is ignored while in BUSY, so the same op never re-triggers.
  - Total: MC_LAT-1 stall cycles and MC_LAT cycles of E occupancy. A back-to-back multi-cycle op restarts from IDLE on the following cycle.
- Load-use vs multi-cycle: if lu and a multi-cycle stall are both active, the multi-cycle stall wins and flushE=0.
- Branch: branch_M=1 gives flushD=flushE=1 and stallF=stallD=stallE=0; this overrides all stall sources. If the FSM is in BUSY, it aborts to IDLE and cnt=0 at the next edge.
- mcBusy = (state==BUSY).
- Counters:
  - stallCount increments on each edge where stallD=1; flushCount increments on each edge where branch_M=1.
  - Both saturate at all-ones.
  - clrCounters=1 zeroes both at the next edge and has priority over increment.
- Reset (reset_n=0, asynchronous):
  - State, cnt and both counters go to IDLE/0 immediately.
  - stallF/D/E, flushD/E and mcBusy are forced to 0 while reset_n=0.
  - forwardA/B remain combinational.
  - Reset during BUSY abandons the op; after release the FSM is in IDLE.

Test Plan:
1. rsE=3, rdM=3/writeM=1, rdW=3/writeW=1 -> forwardA=01. Then writeM=0 -> forwardA=10. Then ZERO_REG_EN=1 with all registers = 0 -> forwardA=00.
2. loadE=1, destRegE=5, rtD=5 for 1 cycle -> stallF=stallD=flushE=1, stallE=0; stallCount goes 0->1.
3. MC_LAT=4, mcStartE held until release -> stallF/D/E high for exactly 3 cycles, mcBusy high for cycles 2-4, FSM back to IDLE after cycle 4. Repeat with MC_LAT=2 -> 1 stall cycle.
4. branch_M=1 in the 2nd cycle of a multi-cycle op -> that cycle: flushD=flushE=1, all stalls 0; next cycle: mcBusy=0; flushCount=1.
5. Assert reset_n=0 mid-BUSY with stallCount=7 -> outputs and counters 0 immediately. After release, a new mcStartE gives the full MC_LAT-1 stall cycles.
6. CNT_W=4, hold stallD for 20 cycles -> stallCount saturates at 15. Then clrCounters together with stallD=1 -> stallCount=0.

Source files
------------

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for a 5-stage pipeline: M/W operand forwarding, load-use bubbles,
// multi-cycle E-stage occupancy tracking, branch flushes and saturating event counters.
module hazard_ctrl_mc #(
   parameter int REG_W       = 4,
   parameter bit ZERO_REG_EN = 1'b1,
   parameter int MC_LAT      = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [REG_W-1:0] rsD,
   input  logic [REG_W-1:0] rtD,
   input  logic [REG_W-1:0] rsE,
   input  logic [REG_W-1:0] rtE,
   input  logic [REG_W-1:0] destRegE,
   input  logic             loadE,
   input  logic             mcStartE,
   input  logic             writeM,
   input  logic [REG_W-1:0] rdM,
   input  logic             writeW,
   input  logic [REG_W-1:0] rdW,
   input  logic             branch_M,
   input  logic             clrCounters,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             flushD,
   output logic             flushE,
   output logic [1:0]       forwardA,
   output logic [1:0]       forwardB,
   output logic             mcBusy,
   output logic [CNT_W-1:0] stallCount,
   output logic [CNT_W-1:0] flushCount
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   // The start cycle is spent in IDLE, so BUSY only needs to cover the remaining MC_LAT-1 cycles.
   localparam logic [7:0] CNT_INIT = 8'(MC_LAT - 2);

   state_t     state_reg, state_next;
   logic [7:0] cnt_reg, cnt_next;
   logic       lu;
   logic       mc_stall;

   function automatic logic reg_ok(input logic [REG_W-1:0] r);
      return !ZERO_REG_EN || (r != '0);
   endfunction

   logic [REG_W-1:0] src_e [2];
   logic [1:0]       fwd_sel [2];

   assign src_e[0] = rsE;
   assign src_e[1] = rtE;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         assign fwd_sel[gi] = (writeM && (rdM == src_e[gi]) && reg_ok(rdM)) ? 2'b01 :
                              (writeW && (rdW == src_e[gi]) && reg_ok(rdW)) ? 2'b10 : 2'b00;
      end
   endgenerate

   assign forwardA = fwd_sel[0];
   assign forwardB = fwd_sel[1];

   assign lu       = loadE && ((destRegE == rsD) || (destRegE == rtD)) && reg_ok(destRegE);
   assign mc_stall = ((state_reg == IDLE) && mcStartE) || ((state_reg == BUSY) && (cnt_reg != 8'd0));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         cnt_reg   <= 8'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (branch_M) begin
         state_next = IDLE;
         cnt_next   = 8'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (mcStartE) begin
                  state_next = BUSY;
                  cnt_next   = CNT_INIT;
               end
            end
            BUSY: begin
               if (cnt_reg != 8'd0) begin
                  cnt_next = cnt_reg - 8'd1;
               end else begin
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = 8'd0;
            end
         endcase
      end
   end

   // A branch squashes everything younger, so it overrides every stall source.
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      mcBusy = 1'b0;
      if (reset_n) begin
         mcBusy = (state_reg == BUSY);
         if (branch_M) begin
            flushD = 1'b1;
            flushE = 1'b1;
         end else begin
            stallE = mc_stall;
            stallF = mc_stall || lu;
            stallD = mc_stall || lu;
            flushE = lu && !mc_stall;
         end
      end
   end

   logic [1:0] cnt_inc;
   assign cnt_inc = {branch_M, stallD};

   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [CNT_W-1:0] count_reg;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               count_reg <= '0;
            end else if (clrCounters) begin
               count_reg <= '0;
            end else if (cnt_inc[gi] && !(&count_reg)) begin
               count_reg <= count_reg + CNT_W'(1);
            end
         end
      end
   endgenerate

   assign stallCount = g_cnt[0].count_reg;
   assign flushCount = g_cnt[1].count_reg;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Randomized bench for hazard_ctrl_mc: two configurations driven in lockstep and
// compared every cycle against a cycle-position occupancy model.
module tb_hazard_ctrl_mc;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] rsD, rtD, rsE, rtE, destRegE, rdM, rdW;
   logic       loadE, mcStartE, writeM, writeW, branch_M, clrCounters;

   logic        sF [2], sD [2], sE [2], fD [2], fE [2], busy [2];
   logic [1:0]  fa [2], fb [2];
   logic [15:0] sc0, fc0;
   logic [3:0]  sc1, fc1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Instance 0: default config. Instance 1: shortest latency, narrow counters, r0 forwardable.
   int MCL  [2] = '{4, 2};
   bit ZR   [2] = '{1'b1, 1'b0};
   int MAXC [2] = '{65535, 15};

   // pos = cycles the current multi-cycle op has already spent in E (-1 = none)
   int pos [2], scnt [2], fcnt [2];
   int pos_nx [2], scnt_nx [2], fcnt_nx [2];

   always #5 clk = ~clk;

   hazard_ctrl_mc #(.REG_W(4), .ZERO_REG_EN(1'b1), .MC_LAT(4), .CNT_W(16)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .destRegE(destRegE), .loadE(loadE), .mcStartE(mcStartE), .writeM(writeM), .rdM(rdM),
      .writeW(writeW), .rdW(rdW), .branch_M(branch_M), .clrCounters(clrCounters),
      .stallF(sF[0]), .stallD(sD[0]), .stallE(sE[0]), .flushD(fD[0]), .flushE(fE[0]),
      .forwardA(fa[0]), .forwardB(fb[0]), .mcBusy(busy[0]), .stallCount(sc0), .flushCount(fc0)
   );

   hazard_ctrl_mc #(.REG_W(4), .ZERO_REG_EN(1'b0), .MC_LAT(2), .CNT_W(4)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .destRegE(destRegE), .loadE(loadE), .mcStartE(mcStartE), .writeM(writeM), .rdM(rdM),
      .writeW(writeW), .rdW(rdW), .branch_M(branch_M), .clrCounters(clrCounters),
      .stallF(sF[1]), .stallD(sD[1]), .stallE(sE[1]), .flushD(fD[1]), .flushE(fE[1]),
      .forwardA(fa[1]), .forwardB(fb[1]), .mcBusy(busy[1]), .stallCount(sc1), .flushCount(fc1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int fwd_model(input logic [3:0] src, input bit zr);
      if (writeM && rdM == src && (!zr || rdM != 0)) return 1;
      if (writeW && rdW == src && (!zr || rdW != 0)) return 2;
      return 0;
   endfunction

   // Inputs are set just after a falling edge; outputs are sampled 1 time unit later.
   task automatic step();
      int  pn, e_fa, e_fb;
      bit  lu, mcs, e_sF, e_sE, e_fD, e_fE, e_busy;
      #1;
      for (int k = 0; k < 2; k++) begin
         if (!reset_n) begin
            pos[k] = -1; scnt[k] = 0; fcnt[k] = 0;
         end
         e_fa = fwd_model(rsE, ZR[k]);
         e_fb = fwd_model(rtE, ZR[k]);
         lu   = loadE && (destRegE == rsD || destRegE == rtD) && (!ZR[k] || destRegE != 0);
         pn   = (pos[k] < 0 && mcStartE) ? 0 : pos[k];
         mcs  = (pn >= 0) && (pn < MCL[k] - 1);
         e_sF = 0; e_sE = 0; e_fD = 0; e_fE = 0; e_busy = 0;
         if (reset_n) begin
            e_busy = (pos[k] >= 1);
            if (branch_M) begin
               e_fD = 1; e_fE = 1;
            end else begin
               e_sE = mcs; e_sF = mcs || lu; e_fE = lu && !mcs;
            end
         end
         check($sformatf("i%0d forwardA", k), 32'(fa[k]), 32'(e_fa));
         check($sformatf("i%0d forwardB", k), 32'(fb[k]), 32'(e_fb));
         check($sformatf("i%0d stallF", k), 32'(sF[k]), 32'(e_sF));
         check($sformatf("i%0d stallD", k), 32'(sD[k]), 32'(e_sF));
         check($sformatf("i%0d stallE", k), 32'(sE[k]), 32'(e_sE));
         check($sformatf("i%0d flushD", k), 32'(fD[k]), 32'(e_fD));
         check($sformatf("i%0d flushE", k), 32'(fE[k]), 32'(e_fE));
         check($sformatf("i%0d mcBusy", k), 32'(busy[k]), 32'(e_busy));
         check($sformatf("i%0d stallCount", k), (k == 0) ? 32'(sc0) : 32'(sc1), 32'(scnt[k]));
         check($sformatf("i%0d flushCount", k), (k == 0) ? 32'(fc0) : 32'(fc1), 32'(fcnt[k]));
         if (branch_M || !mcs) pos_nx[k] = -1;
         else                  pos_nx[k] = pn + 1;
         if (clrCounters) begin
            scnt_nx[k] = 0; fcnt_nx[k] = 0;
         end else begin
            scnt_nx[k] = (e_sF && scnt[k] < MAXC[k]) ? scnt[k] + 1 : scnt[k];
            fcnt_nx[k] = (branch_M && fcnt[k] < MAXC[k]) ? fcnt[k] + 1 : fcnt[k];
         end
      end
      $display("cyc %0d rst_n=%0b ld=%0b mc=%0b br=%0b clr=%0b | i0 st=%0b busy=%0b sc=%0d fc=%0d | i1 st=%0b busy=%0b sc=%0d fc=%0d",
               cyc, reset_n, loadE, mcStartE, branch_M, clrCounters,
               sD[0], busy[0], sc0, fc0, sD[1], busy[1], sc1, fc1);
      @(posedge clk);
      if (reset_n) begin
         for (int k = 0; k < 2; k++) begin
            pos[k] = pos_nx[k]; scnt[k] = scnt_nx[k]; fcnt[k] = fcnt_nx[k];
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic quiet();
      {rsD, rtD, rsE, rtE, destRegE, rdM, rdW} = '0;
      {loadE, mcStartE, writeM, writeW, branch_M, clrCounters} = '0;
   endtask

   task automatic rand_in();
      rsD = 4'($urandom_range(0, 3)); rtD = 4'($urandom_range(0, 3));
      rsE = 4'($urandom_range(0, 3)); rtE = 4'($urandom_range(0, 3));
      destRegE = 4'($urandom_range(0, 3));
      rdM = 4'($urandom_range(0, 3)); rdW = 4'($urandom_range(0, 3));
      writeM = 1'($urandom_range(0, 1)); writeW = 1'($urandom_range(0, 1));
      loadE       = ($urandom_range(0, 2) == 0);
      mcStartE    = ($urandom_range(0, 2) == 0);
      branch_M    = ($urandom_range(0, 11) == 0);
      clrCounters = ($urandom_range(0, 39) == 0);
      reset_n     = ($urandom_range(0, 49) != 0);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         pos[k] = -1; scnt[k] = 0; fcnt[k] = 0;
      end
      quiet();
      reset_n = 1'b0;
      @(negedge clk);
      step();
      reset_n = 1'b1;

      // Forwarding priority, then W-only, then the zero register.
      rsE = 4'd3; rdM = 4'd3; writeM = 1'b1; rdW = 4'd3; writeW = 1'b1;
      step();
      writeM = 1'b0;
      step();
      rsE = 4'd0; rdM = 4'd0; rdW = 4'd0; writeM = 1'b1;
      step();

      // Single load-use cycle, then a held multi-cycle op with a branch in its 2nd cycle.
      quiet(); loadE = 1'b1; destRegE = 4'd5; rtD = 4'd5;
      step();
      quiet(); mcStartE = 1'b1;
      step();
      branch_M = 1'b1;
      step();
      branch_M = 1'b0; mcStartE = 1'b0;
      step();
      mcStartE = 1'b1;
      repeat (5) step();
      mcStartE = 1'b0;
      step();

      for (int n = 0; n < 500; n++) begin
         rand_in();
         step();
      end
      reset_n = 1'b1;

      // Drive both counters into saturation, then clear against a live stall.
      quiet(); loadE = 1'b1; destRegE = 4'd1; rsD = 4'd1;
      repeat (20) step();
      branch_M = 1'b1;
      repeat (20) step();
      branch_M = 1'b0; clrCounters = 1'b1;
      step();
      clrCounters = 1'b0;
      step();

      // Reset in the middle of an op, then a complete fresh op.
      quiet(); mcStartE = 1'b1;
      repeat (2) step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      repeat (5) step();
      quiet();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
